// File: rtl/roberts_mdc_stream_source.sv
// Roberts MDC stream source: frames accelerator words into an
// HWPE-Stream source through a 2-entry elastic buffer.
module roberts_mdc_stream_source #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    len_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_WIDTH-1:0]    cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    len_q, len_d;
    logic [CNT_WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   buf_q [2];
    logic [DATA_WIDTH-1:0]   buf_d [2];
    logic                    wptr_q, wptr_d;
    logic                    rptr_q, rptr_d;
    logic [1:0]              occ_q, occ_d;
    logic                    push, pop;

    // Handshakes and stream outputs, all derived from registered state
    always_comb begin
        in_ready_o  = (state_q == RUN) && (occ_q != 2'd2) && (acc_q < len_q);
        out_valid_o = (state_q == RUN) && (occ_q != 2'd0);
        out_data_o  = out_valid_o ? buf_q[rptr_q] : '0;
        out_strb_o  = out_valid_o ? '1 : '0;
        busy_o      = (state_q == RUN);
        done_o      = (state_q == DONE);
        cnt_o       = cnt_q;
        push        = in_valid_i && in_ready_o;
        pop         = out_valid_o && out_ready_i;
    end

    // Next-state logic for framing FSM, counters and elastic buffer
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        occ_d   = occ_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    wptr_d  = 1'b0;
                    rptr_d  = 1'b0;
                    occ_d   = 2'd0;
                    state_d = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (push) begin
                    buf_d[wptr_q] = in_data_i;
                    wptr_d        = ~wptr_q;
                    acc_d         = acc_q + CNT_ONE;
                end
                if (pop) begin
                    rptr_d = ~rptr_q;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q + CNT_ONE == len_q) begin
                        state_d = DONE;
                    end
                end
                case ({push, pop})
                    2'b10:   occ_d = occ_q + 2'd1;
                    2'b01:   occ_d = occ_q - 2'd1;
                    default: occ_d = occ_q;
                endcase
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset and soft clear
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q  <= IDLE;
            len_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: tb/tb_roberts_mdc_stream_source.sv
// Directed bench for roberts_mdc_stream_source.
// Drives/samples 1 time unit after each rising edge.
module tb_roberts_mdc_stream_source;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        start_i;
    logic [15:0] len_i;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic [3:0]  out_strb_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] cnt_o;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    roberts_mdc_stream_source #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .out_data_o (out_data_o),
        .out_strb_o (out_strb_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cnt_o      (cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // One frame: words base, base+1, ...; out_ready_i low for the
    // first `stall` cycles; optional start re-pulse while busy.
    task automatic run_frame(input int len, input logic [31:0] base,
                             input int stall, input bit repulse);
        int acc, emit, dones, f_acc, f_vld;
        logic [31:0] prev_data;
        bit prev_hold;
        acc = 0; emit = 0; dones = 0;
        f_acc = -1; f_vld = -1;
        prev_hold = 1'b0; prev_data = '0;
        start_i     = 1'b1;
        len_i       = 16'(len);
        in_valid_i  = 1'b1;
        in_data_i   = base;
        out_ready_i = (stall == 0);
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            out_ready_i = (i >= stall);
            start_i     = repulse && (i == 1);
            len_i       = (repulse && (i == 1)) ? 16'd7 : 16'(len);
            in_data_i   = base + 32'(acc);
            if (prev_hold)
                chk("hold", out_data_o, prev_data);
            if (stall > 0 && i == stall - 1) begin
                chk("stall_acc", 32'(acc), 32'd2);
                chk("stall_rdy", 32'(in_ready_o), 32'd0);
            end
            chk("busy", 32'(busy_o), 32'(!done_o));
            if (out_valid_o && f_vld < 0) f_vld = i;
            if (out_valid_o)
                chk("strb", 32'(out_strb_o), 32'hf);
            if (out_valid_o && out_ready_i) begin
                chk("data", out_data_o, base + 32'(emit));
                emit++;
            end
            prev_hold = out_valid_o && !out_ready_i;
            prev_data = out_data_o;
            if (in_valid_i && in_ready_o) begin
                if (f_acc < 0) f_acc = i;
                acc++;
            end
            if (done_o) begin
                dones++;
                break;
            end
            cyc();
        end
        start_i = 1'b0;
        chk("emit", 32'(emit), 32'(len));
        chk("acc", 32'(acc), 32'(len));
        chk("done_cnt", 32'(dones), 32'd1);
        chk("cnt", 32'(cnt_o), 32'(len));
        chk("latency", 32'(f_vld), 32'(f_acc + 1));
        cyc();
        chk("done_1cyc", 32'(done_o), 32'd0);
        chk("cnt_hold", 32'(cnt_o), 32'(len));
        in_valid_i = 1'b0;
        cyc();
    endtask

    initial begin
        int acc;
        bit seen;
        rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
        len_i = '0; in_data_i = '0; in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        cyc(); cyc();
        chk("rst_rdy", 32'(in_ready_o), 32'd0);
        chk("rst_vld", 32'(out_valid_o), 32'd0);
        chk("rst_data", out_data_o, 32'd0);
        chk("rst_strb", 32'(out_strb_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        rst_ni = 1'b1;
        cyc();

        run_frame(4, 32'h10, 0, 1'b0);
        run_frame(3, 32'h20, 5, 1'b0);
        run_frame(2, 32'h30, 0, 1'b0);

        start_i = 1'b1; len_i = 16'd0; in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        cyc();
        start_i = 1'b0;
        chk("z_done", 32'(done_o), 32'd1);
        chk("z_vld", 32'(out_valid_o), 32'd0);
        chk("z_cnt", 32'(cnt_o), 32'd0);
        chk("z_busy", 32'(busy_o), 32'd0);
        cyc();
        chk("z_done1", 32'(done_o), 32'd0);
        chk("z_vld1", 32'(out_valid_o), 32'd0);
        in_valid_i = 1'b0;
        cyc();

        acc = 0;
        start_i = 1'b1; len_i = 16'd5; in_valid_i = 1'b1;
        in_data_i = 32'h50; out_ready_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data_i = 32'h50 + 32'(acc);
            if (cnt_o == 16'd1) break;
            if (in_valid_i && in_ready_o) acc++;
            cyc();
        end
        chk("clr_reach", 32'(cnt_o), 32'd1);
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        chk("clr_vld", 32'(out_valid_o), 32'd0);
        chk("clr_busy", 32'(busy_o), 32'd0);
        chk("clr_cnt", 32'(cnt_o), 32'd0);
        chk("clr_rdy", 32'(in_ready_o), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_o) seen = 1'b1;
            cyc();
        end
        chk("clr_nodone", 32'(seen), 32'd0);
        in_valid_i = 1'b0;
        cyc();

        run_frame(1, 32'h60, 0, 1'b0);
        run_frame(3, 32'h70, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/roberts_mdc_stream_source.md
Name: roberts_mdc_stream_source

Overview:
- Transmit-side stream adapter for the Roberts MDC accelerator.
- Accepts a flat valid/ready/data word stream from the accelerator datapath and drives the flat fields of an HWPE-Stream source: data, strb, valid and ready.
- Frames the transfer to a programmed word count, buffers it through a 2-entry elastic buffer for full throughput, and reports completion to the controller.

Parameters:
- DATA_WIDTH, 32, word width of data in and data out.
- CNT_WIDTH, 16, width of the frame-length and word counters.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_ni  input  1  synchronous active-low reset.
- clear_i  input  1  synchronous soft clear, active-high.
- start_i  input  1  start a frame; sampled only in IDLE.
- len_i  input  CNT_WIDTH  frame length in words; sampled with start_i.
- in_data_i  input  DATA_WIDTH  word from the accelerator.
- in_valid_i  input  1  in_data_i is valid.
- in_ready_o  output  1  block accepts in_data_i.
- out_data_o  output  DATA_WIDTH  HWPE-Stream data.
- out_strb_o  output  DATA_WIDTH/8  HWPE-Stream byte strobe.
- out_valid_o  output  1  HWPE-Stream valid.
- out_ready_i  input  1  HWPE-Stream ready.
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle frame-complete pulse.
- cnt_o  output  CNT_WIDTH  words emitted in the current or last frame.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE, buffer empty, counters 0.
  - in_ready_o=0, out_valid_o=0, out_data_o=0, out_strb_o=0, busy_o=0, done_o=0, cnt_o=0.
- clear_i=1 has the same effect as reset: buffered words are discarded and no done_o is issued. Reset or clear asserted mid-frame aborts the frame.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready_o=0, busy_o=0.
  - start_i=1 with len_i!=0: latch len, clear both counters, go to RUN.
  - start_i=1 with len_i==0: go to DONE, so done_o pulses on the next cycle with cnt_o=0.
- RUN:
  - busy_o=1.
  - Input side: in_ready_o = (buffer occupancy<2) AND (accepted<len). Words beyond len are never accepted.
  - Input handshake: in_valid_i AND in_ready_o. The word is written to the buffer tail and accepted++.
  - Output side: out_valid_o = buffer not empty. out_data_o is the buffer head. out_strb_o is all ones when out_valid_o=1, otherwise 0.
  - Output handshake: out_valid_o AND out_ready_i. The head is popped and cnt_o++.
  - When the handshake that makes cnt_o==len completes, go to DONE.
- DONE:
  - done_o=1 for exactly one cycle, busy_o=0, then go to IDLE.
  - cnt_o holds its value until the next start.
- start_i outside IDLE is ignored.
- Latency:
  - A word accepted in cycle t is visible on out_data_o/out_valid_o in cycle t+1 (registered output, no combinational in-to-out path).
  - in_ready_o depends only on registered state, not on out_ready_i.
- Throughput: 1 word/cycle sustained when out_ready_i is held high.
- Simultaneous push and pop:
  - Occupancy stays unchanged.
  - A push into a full buffer is impossible because in_ready_o=0.
  - A pop of the last word and a push in the same cycle leaves the new word as head next cycle.
- Stream stability: once out_valid_o=1, out_valid_o and out_data_o stay stable until the handshake, except on reset or clear.
- Buffer: 2 entries, head/tail pointers 1 bit, wrap-around modulo 2.
- Counters are CNT_WIDTH bits. The maximum frame is 2^CNT_WIDTH-1 words, with no wrap inside a frame.

Test Plan:
- Reset, then start_i with len_i=4, in_valid_i=1 and out_ready_i=1 constantly, data 0x10..0x13:
  - out words are 0x10,0x11,0x12,0x13 on 4 consecutive cycles, the first one cycle after the first input acceptance.
  - done_o pulses once and cnt_o=4.
- len_i=3, out_ready_i=0 for the first 5 cycles:
  - in_ready_o drops after 2 accepts.
  - out_data_o holds the first word stable.
  - After ready rises, all 3 words drain in order, then done_o pulses.
- len_i=2 with in_valid_i held 1 past the frame: in_ready_o=0 after 2 accepts and exactly 2 words are emitted.
- start_i with len_i=0: no output valid, done_o=1 exactly one cycle later, cnt_o=0.
- Mid-frame clear_i after 1 of 5 words emitted:
  - Next cycle out_valid_o=0, busy_o=0, cnt_o=0, and no done_o pulse.
  - A new start with len_i=1 completes normally.
- start_i pulsed while busy with a different len_i: ignored, and the original frame length completes.
